spec_mem_tracker: RTL and testbench

SPEC_MEM_TRACKER -- requirements
Module: spec_mem_tracker

---
 rtl/spec_mem_pkg.sv | 25 ++
 rtl/spec_mem_tracker_if.sv | 25 ++
 rtl/spec_mem_tracker.sv | 181 ++++++++++++++++++
 tb/tb_spec_mem_tracker.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spec_mem_pkg.sv
// spec_mem_pkg
//   Shared types for the memory-access tracker: the tracker FSM state,
//   the per-granule record kept for each data-bus transfer, and the
//   slot-count limit.
package spec_mem_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_PENDING  = 2'd1,
    ST_COMPLETE = 2'd2
  } mem_state_e;

  // One granule of a (possibly misaligned, hence split) data access.
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } gran_rec_t;

  localparam int unsigned NumSlots = 2;
  localparam logic [1:0]  GcntMax  = 2'd2;

endpackage

// File: rtl/spec_mem_tracker_if.sv
// spec_mem_tracker_if
//   Core data-bus signals observed by the tracker.
//   master : the core side driving request, grant and response
//   slave  : the tracker, which only observes every signal
interface spec_mem_tracker_if;
  logic        data_req_i;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic        data_we_i;
  logic        data_err_i;
  logic [31:0] data_addr_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_i;

  modport master (
    output data_req_i, data_gnt_i, data_rvalid_i, data_we_i, data_err_i,
    output data_addr_i, data_be_i, data_wdata_i, data_rdata_i
  );

  modport slave (
    input data_req_i, data_gnt_i, data_rvalid_i, data_we_i, data_err_i,
    input data_addr_i, data_be_i, data_wdata_i, data_rdata_i
  );
endinterface

// File: rtl/spec_mem_tracker.sv
// spec_mem_tracker
//   Records the data-bus granules (at most two) issued by the instruction
//   currently being checked, together with their responses, and presents
//   the record to a specification model.
// Ports
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   bus (slave)            : observed core data-bus handshake and payload
//   instr_done_i           : checked instruction retired; clears the record
//   mem_read_* / mem_write_*: granule-presence flags and slot payloads
//   mem_complete_o         : every granted granule has received its rvalid
//   mem_err_o              : some response of this record carried an error
//   prot_err_o             : sticky bus-protocol violation (ProtChkEn only)
module spec_mem_tracker
  import spec_mem_pkg::*;
#(
  parameter bit ProtChkEn = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  spec_mem_tracker_if.slave   bus,
  input  logic                instr_done_i,
  output logic                mem_read_o,
  output logic                mem_read_snd_gran_o,
  output logic                mem_write_o,
  output logic                mem_write_snd_gran_o,
  output logic [31:0]         mem_read_fst_addr_o,
  output logic [31:0]         mem_read_snd_addr_o,
  output logic [31:0]         mem_read_fst_rdata_o,
  output logic [31:0]         mem_read_snd_rdata_o,
  output logic [31:0]         mem_write_fst_addr_o,
  output logic [31:0]         mem_write_snd_addr_o,
  output logic [31:0]         mem_write_fst_wdata_o,
  output logic [31:0]         mem_write_snd_wdata_o,
  output logic [3:0]          mem_write_fst_be_o,
  output logic [3:0]          mem_write_snd_be_o,
  output logic                mem_complete_o,
  output logic                mem_err_o,
  output logic                prot_err_o
);

  mem_state_e state_reg, state_next;
  logic [1:0] gcnt_reg, gcnt_next;
  logic [1:0] rcnt_reg, rcnt_next;
  logic       err_reg, err_next;
  gran_rec_t  slot_reg  [NumSlots];
  gran_rec_t  slot_next [NumSlots];

  logic gnt_fire;
  logic gnt_acc;
  logic rv_acc;
  logic prot_hit;

  assign gnt_fire = bus.data_req_i & bus.data_gnt_i;

  // Counter / slot update. instr_done_i wins over the running record, but a
  // grant in the same cycle opens the next record in slot 0. Responses in a
  // retiring cycle belong to the record being discarded and are ignored.
  always_comb begin
    gcnt_next = gcnt_reg;
    rcnt_next = rcnt_reg;
    err_next  = err_reg;
    slot_next = slot_reg;
    gnt_acc   = 1'b0;
    rv_acc    = 1'b0;
    prot_hit  = 1'b0;

    if (instr_done_i) begin
      // Retiring with responses still owed means the core dropped one.
      if (rcnt_reg < gcnt_reg) prot_hit = 1'b1;
      gcnt_next = 2'd0;
      rcnt_next = 2'd0;
      err_next  = 1'b0;
      if (gnt_fire) begin
        gnt_acc            = 1'b1;
        slot_next[0].addr  = bus.data_addr_i;
        slot_next[0].we    = bus.data_we_i;
        slot_next[0].be    = bus.data_be_i;
        slot_next[0].wdata = bus.data_wdata_i;
        gcnt_next          = 2'd1;
      end
    end else begin
      if (gnt_fire) begin
        if (gcnt_reg == GcntMax) begin
          // Third granule: not recordable, counters stay saturated.
          prot_hit = 1'b1;
        end else begin
          gnt_acc                       = 1'b1;
          slot_next[gcnt_reg[0]].addr   = bus.data_addr_i;
          slot_next[gcnt_reg[0]].we     = bus.data_we_i;
          slot_next[gcnt_reg[0]].be     = bus.data_be_i;
          slot_next[gcnt_reg[0]].wdata  = bus.data_wdata_i;
          gcnt_next                     = gcnt_reg + 2'd1;
          // Both halves of a split access must share a direction.
          if ((gcnt_reg == 2'd1) && (bus.data_we_i != slot_reg[0].we))
            prot_hit = 1'b1;
        end
      end
      if (bus.data_rvalid_i) begin
        // Compare against the pre-grant count: a response can never belong
        // to a granule granted in the same cycle.
        if (rcnt_reg == gcnt_reg) begin
          prot_hit = 1'b1;
        end else begin
          rv_acc                        = 1'b1;
          slot_next[rcnt_reg[0]].rdata  = bus.data_rdata_i;
          rcnt_next                     = rcnt_reg + 2'd1;
          err_next                      = err_reg | bus.data_err_i;
        end
      end
    end
  end

  // FSM next state
  always_comb begin
    state_next = state_reg;
    if (instr_done_i) begin
      state_next = gnt_acc ? ST_PENDING : ST_EMPTY;
    end else begin
      unique case (state_reg)
        ST_EMPTY:    if (gnt_acc) state_next = ST_PENDING;
        ST_PENDING:  if (rv_acc && (rcnt_next == gcnt_next)) state_next = ST_COMPLETE;
        ST_COMPLETE: if (gnt_acc) state_next = ST_PENDING;
        default:     state_next = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= ST_EMPTY;
      gcnt_reg  <= 2'd0;
      rcnt_reg  <= 2'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      gcnt_reg  <= gcnt_next;
      rcnt_reg  <= rcnt_next;
      err_reg   <= err_next;
    end
  end

  // Slot payloads are never cleared by instr_done_i; only overwritten.
  for (genvar gi = 0; gi < NumSlots; gi++) begin : g_slot
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) slot_reg[gi] <= '0;
      else         slot_reg[gi] <= slot_next[gi];
    end
  end

  if (ProtChkEn) begin : g_prot
    logic prot_reg;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) prot_reg <= 1'b0;
      else         prot_reg <= prot_reg | prot_hit;
    end
    assign prot_err_o = prot_reg;
  end else begin : g_no_prot
    assign prot_err_o = 1'b0;
  end

  // Direction of the record is taken from slot 0.
  assign mem_read_o           = (gcnt_reg != 2'd0) & ~slot_reg[0].we;
  assign mem_read_snd_gran_o  = (gcnt_reg == 2'd2) & ~slot_reg[0].we;
  assign mem_write_o          = (gcnt_reg != 2'd0) &  slot_reg[0].we;
  assign mem_write_snd_gran_o = (gcnt_reg == 2'd2) &  slot_reg[0].we;

  assign mem_read_fst_addr_o   = slot_reg[0].addr;
  assign mem_read_snd_addr_o   = slot_reg[1].addr;
  assign mem_read_fst_rdata_o  = slot_reg[0].rdata;
  assign mem_read_snd_rdata_o  = slot_reg[1].rdata;
  assign mem_write_fst_addr_o  = slot_reg[0].addr;
  assign mem_write_snd_addr_o  = slot_reg[1].addr;
  assign mem_write_fst_wdata_o = slot_reg[0].wdata;
  assign mem_write_snd_wdata_o = slot_reg[1].wdata;
  assign mem_write_fst_be_o    = slot_reg[0].be;
  assign mem_write_snd_be_o    = slot_reg[1].be;

  assign mem_complete_o = (state_reg == ST_COMPLETE);
  assign mem_err_o      = err_reg;

endmodule

// File: tb/tb_spec_mem_tracker.sv
module tb_spec_mem_tracker;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        instr_done = 1'b0;
  logic        rd, rd_snd, wr, wr_snd, complete, err, prot;
  logic [31:0] rd_fst_addr, rd_snd_addr, rd_fst_data, rd_snd_data;
  logic [31:0] wr_fst_addr, wr_snd_addr, wr_fst_data, wr_snd_data;
  logic [3:0]  wr_fst_be, wr_snd_be;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] fst_addr;
    logic [31:0] snd_addr;
    logic [31:0] fst_data;
    logic [31:0] snd_data;
    logic        snd;
    logic        err;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  spec_mem_tracker_if bus_if ();

  spec_mem_tracker #(.ProtChkEn(1'b1)) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_ni),
    .bus                   (bus_if.slave),
    .instr_done_i          (instr_done),
    .mem_read_o            (rd),
    .mem_read_snd_gran_o   (rd_snd),
    .mem_write_o           (wr),
    .mem_write_snd_gran_o  (wr_snd),
    .mem_read_fst_addr_o   (rd_fst_addr),
    .mem_read_snd_addr_o   (rd_snd_addr),
    .mem_read_fst_rdata_o  (rd_fst_data),
    .mem_read_snd_rdata_o  (rd_snd_data),
    .mem_write_fst_addr_o  (wr_fst_addr),
    .mem_write_snd_addr_o  (wr_snd_addr),
    .mem_write_fst_wdata_o (wr_fst_data),
    .mem_write_snd_wdata_o (wr_snd_data),
    .mem_write_fst_be_o    (wr_fst_be),
    .mem_write_snd_be_o    (wr_snd_be),
    .mem_complete_o        (complete),
    .mem_err_o             (err),
    .prot_err_o            (prot)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus_if.data_req_i    = 1'b0;
    bus_if.data_gnt_i    = 1'b0;
    bus_if.data_rvalid_i = 1'b0;
    bus_if.data_we_i     = 1'b0;
    bus_if.data_err_i    = 1'b0;
    bus_if.data_addr_i   = '0;
    bus_if.data_be_i     = '0;
    bus_if.data_wdata_i  = '0;
    bus_if.data_rdata_i  = '0;
  endtask

  task automatic grant(input logic [31:0] a, input logic we, input logic [3:0] be,
                       input logic [31:0] wd);
    bus_if.data_req_i   = 1'b1;
    bus_if.data_gnt_i   = 1'b1;
    bus_if.data_addr_i  = a;
    bus_if.data_we_i    = we;
    bus_if.data_be_i    = be;
    bus_if.data_wdata_i = wd;
  endtask

  task automatic resp(input logic [31:0] d, input logic er);
    bus_if.data_rvalid_i = 1'b1;
    bus_if.data_rdata_i  = d;
    bus_if.data_err_i    = er;
  endtask

  task automatic done_pulse;
    instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
  endtask

  task automatic test_reset;
    idle();
    rst_ni = 1'b0;
    tick(); tick();
    n_cmp++; if (complete !== 1'b0) begin n_err++; $display("FAIL reset_complete got %b want 0", complete); end
    n_cmp++; if ({rd, rd_snd, wr, wr_snd} !== 4'b0) begin n_err++; $display("FAIL reset_flags got %b want 0000", {rd, rd_snd, wr, wr_snd}); end
    n_cmp++; if ({err, prot} !== 2'b0) begin n_err++; $display("FAIL reset_err got %b want 00", {err, prot}); end
    n_cmp++; if ({rd_fst_addr, rd_snd_data, wr_snd_be} !== 68'h0) begin n_err++; $display("FAIL reset_payload got %h want 0", {rd_fst_addr, rd_snd_data, wr_snd_be}); end
    rst_ni = 1'b1;
    tick();
    $display("reset: done");
  endtask

  task automatic test_aligned_load;
    grant(32'h100, 1'b0, 4'hF, 32'h0);
    sb.push_back('{fst_addr: 32'h100, snd_addr: 32'h0, fst_data: 32'hDEADBEEF, snd_data: 32'h0, snd: 1'b0, err: 1'b0});
    tick(); idle();
    resp(32'hDEADBEEF, 1'b0);
    tick(); idle();
    e = sb.pop_front();
    n_cmp++; if (complete !== 1'b1) begin n_err++; $display("FAIL load_complete got %b want 1", complete); end
    n_cmp++; if ({rd, rd_snd, wr} !== 3'b100) begin n_err++; $display("FAIL load_flags got %b want 100", {rd, rd_snd, wr}); end
    n_cmp++; if (rd_fst_addr !== e.fst_addr) begin n_err++; $display("FAIL load_addr got %h want %h", rd_fst_addr, e.fst_addr); end
    n_cmp++; if (rd_fst_data !== e.fst_data) begin n_err++; $display("FAIL load_rdata got %h want %h", rd_fst_data, e.fst_data); end
    done_pulse();
    n_cmp++; if ({complete, rd} !== 2'b00) begin n_err++; $display("FAIL load_clear got %b want 00", {complete, rd}); end
    n_cmp++; if (rd_fst_addr !== 32'h100) begin n_err++; $display("FAIL load_hold got %h want 00000100", rd_fst_addr); end
    $display("aligned_load: addr %h rdata %h", rd_fst_addr, rd_fst_data);
  endtask

  task automatic test_misaligned_store;
    int waited;
    grant(32'h103, 1'b1, 4'b1000, 32'hAABBCCDD);
    tick();
    grant(32'h104, 1'b1, 4'b0111, 32'h00112233);
    sb.push_back('{fst_addr: 32'h103, snd_addr: 32'h104, fst_data: 32'hAABBCCDD, snd_data: 32'h00112233, snd: 1'b1, err: 1'b0});
    tick(); idle();
    n_cmp++; if ({wr, wr_snd, rd} !== 3'b110) begin n_err++; $display("FAIL store_flags got %b want 110", {wr, wr_snd, rd}); end
    n_cmp++; if ({wr_fst_be, wr_snd_be} !== 8'b1000_0111) begin n_err++; $display("FAIL store_be got %b want 10000111", {wr_fst_be, wr_snd_be}); end
    n_cmp++; if (complete !== 1'b0) begin n_err++; $display("FAIL store_early0 got %b want 0", complete); end
    resp(32'h0, 1'b0);
    tick(); idle();
    n_cmp++; if (complete !== 1'b0) begin n_err++; $display("FAIL store_early1 got %b want 0", complete); end
    resp(32'h0, 1'b0);
    tick(); idle();
    waited = 0;
    while (complete !== 1'b1 && waited < 8) begin tick(); waited++; end
    e = sb.pop_front();
    n_cmp++; if (waited !== 0) begin n_err++; $display("FAIL store_complete_latency got %0d want 0", waited); end
    n_cmp++; if ({wr_fst_addr, wr_snd_addr} !== {e.fst_addr, e.snd_addr}) begin n_err++; $display("FAIL store_addr got %h want %h", {wr_fst_addr, wr_snd_addr}, {e.fst_addr, e.snd_addr}); end
    n_cmp++; if ({wr_fst_data, wr_snd_data} !== {e.fst_data, e.snd_data}) begin n_err++; $display("FAIL store_wdata got %h want %h", {wr_fst_data, wr_snd_data}, {e.fst_data, e.snd_data}); end
    done_pulse();
    $display("misaligned_store: snd addr %h be %b", wr_snd_addr, wr_snd_be);
  endtask

  task automatic test_overlap;
    grant(32'h200, 1'b0, 4'hF, 32'h0);
    sb.push_back('{fst_addr: 32'h200, snd_addr: 32'h204, fst_data: 32'h11, snd_data: 32'h22, snd: 1'b1, err: 1'b0});
    tick();
    grant(32'h204, 1'b0, 4'hF, 32'h0);
    resp(32'h11, 1'b0);
    tick(); idle();
    n_cmp++; if (complete !== 1'b0) begin n_err++; $display("FAIL overlap_early got %b want 0", complete); end
    resp(32'h22, 1'b0);
    tick(); idle();
    e = sb.pop_front();
    n_cmp++; if ({complete, rd_snd, prot} !== 3'b110) begin n_err++; $display("FAIL overlap_flags got %b want 110", {complete, rd_snd, prot}); end
    n_cmp++; if ({rd_fst_data, rd_snd_data} !== {e.fst_data, e.snd_data}) begin n_err++; $display("FAIL overlap_rdata got %h want %h", {rd_fst_data, rd_snd_data}, {e.fst_data, e.snd_data}); end
    n_cmp++; if (rd_snd_addr !== e.snd_addr) begin n_err++; $display("FAIL overlap_addr got %h want %h", rd_snd_addr, e.snd_addr); end
    done_pulse();
    $display("overlap: rdata %h %h", rd_fst_data, rd_snd_data);
  endtask

  task automatic test_bus_error;
    grant(32'h300, 1'b0, 4'hF, 32'h0);
    sb.push_back('{fst_addr: 32'h300, snd_addr: 32'h304, fst_data: 32'h1, snd_data: 32'h2, snd: 1'b1, err: 1'b1});
    tick();
    grant(32'h304, 1'b0, 4'hF, 32'h0);
    tick(); idle();
    resp(32'h1, 1'b0);
    tick(); idle();
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL buserr_early got %b want 0", err); end
    resp(32'h2, 1'b1);
    tick(); idle();
    e = sb.pop_front();
    n_cmp++; if ({err, complete} !== {e.err, 1'b1}) begin n_err++; $display("FAIL buserr_set got %b want %b", {err, complete}, {e.err, 1'b1}); end
    done_pulse();
    n_cmp++; if ({err, rd, rd_snd, wr, wr_snd, complete} !== 6'b0) begin n_err++; $display("FAIL buserr_clear got %b want 000000", {err, rd, rd_snd, wr, wr_snd, complete}); end
    $display("bus_error: err cleared to %b", err);
  endtask

  task automatic test_back_to_back;
    grant(32'h400, 1'b0, 4'hF, 32'h0);
    tick(); idle();
    resp(32'h44, 1'b0);
    tick(); idle();
    // retire and open the next record in the same cycle
    grant(32'h500, 1'b0, 4'hF, 32'h0);
    sb.push_back('{fst_addr: 32'h500, snd_addr: 32'h0, fst_data: 32'h55, snd_data: 32'h0, snd: 1'b0, err: 1'b0});
    done_pulse(); idle();
    n_cmp++; if ({rd, rd_snd, complete, prot} !== 4'b1000) begin n_err++; $display("FAIL b2b_flags got %b want 1000", {rd, rd_snd, complete, prot}); end
    resp(32'h55, 1'b0);
    tick(); idle();
    e = sb.pop_front();
    n_cmp++; if ({rd_fst_addr, rd_fst_data} !== {e.fst_addr, e.fst_data}) begin n_err++; $display("FAIL b2b_record got %h want %h", {rd_fst_addr, rd_fst_data}, {e.fst_addr, e.fst_data}); end
    n_cmp++; if ({complete, rd_snd} !== {1'b1, e.snd}) begin n_err++; $display("FAIL b2b_complete got %b want %b", {complete, rd_snd}, {1'b1, e.snd}); end
    done_pulse();
    $display("back_to_back: addr %h rdata %h", rd_fst_addr, rd_fst_data);
  endtask

  task automatic test_violations;
    grant(32'h600, 1'b0, 4'hF, 32'h0); tick();
    grant(32'h604, 1'b0, 4'hF, 32'h0); tick();
    grant(32'h608, 1'b0, 4'hF, 32'h0); tick(); idle();
    n_cmp++; if ({prot, rd_snd} !== 2'b11) begin n_err++; $display("FAIL third_grant got %b want 11", {prot, rd_snd}); end
    n_cmp++; if (rd_snd_addr !== 32'h604) begin n_err++; $display("FAIL third_dropped got %h want 00000604", rd_snd_addr); end
    resp(32'h6, 1'b0); tick();
    resp(32'h7, 1'b0); tick(); idle();
    n_cmp++; if (complete !== 1'b1) begin n_err++; $display("FAIL third_complete got %b want 1", complete); end
    done_pulse();
    n_cmp++; if (prot !== 1'b1) begin n_err++; $display("FAIL prot_sticky got %b want 1", prot); end
    rst_ni = 1'b0; tick(); rst_ni = 1'b1; tick();
    n_cmp++; if (prot !== 1'b0) begin n_err++; $display("FAIL prot_reset got %b want 0", prot); end
    resp(32'h9, 1'b0); tick(); idle();
    n_cmp++; if ({prot, complete} !== 2'b10) begin n_err++; $display("FAIL stray_rvalid got %b want 10", {prot, complete}); end
    rst_ni = 1'b0; tick(); rst_ni = 1'b1; tick();
    grant(32'h700, 1'b0, 4'hF, 32'h0); tick();
    grant(32'h704, 1'b1, 4'hF, 32'h0); tick(); idle();
    n_cmp++; if (prot !== 1'b1) begin n_err++; $display("FAIL we_mismatch got %b want 1", prot); end
    rst_ni = 1'b0; tick(); rst_ni = 1'b1; tick();
    grant(32'h800, 1'b0, 4'hF, 32'h0); tick(); idle();
    rst_ni = 1'b0; tick();
    n_cmp++; if ({prot, rd, rd_fst_addr} !== 34'h0) begin n_err++; $display("FAIL reset_midtxn got %h want 0", {prot, rd, rd_fst_addr}); end
    rst_ni = 1'b1; tick();
    done_pulse();
    n_cmp++; if (prot !== 1'b0) begin n_err++; $display("FAIL done_after_reset got %b want 0", prot); end
    $display("violations: prot %b", prot);
  endtask

  initial begin
    idle();
    test_reset();
    test_aligned_load();
    test_misaligned_store();
    test_overlap();
    test_bus_error();
    test_back_to_back();
    test_violations();
    n_cmp++; if (sb.size() !== 0) begin n_err++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
